mem_store_narrower: RTL

Store-path narrowing unit for the MIPS data memory: the write-side counterpart of the load sign/zero extender. It accepts a 32-bit register value, a byte address and an access size (sb/sh/sw), truncates the value to 8/16/32 bits, and writes it one byte per cycle to the byte-wide data memory port. It sits between the MEM-stage control and the data RAM, and it flags misaligned or reserved-size stores instead of writing.

---
 rtl/mem_store_narrower.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_store_narrower.sv
// -----------------------------------------------------------------------------
// mem_store_narrower
//
// Store-path narrowing unit for the MIPS data memory. A 32-bit register value
// is truncated to the access size (byte / halfword / word) and written to a
// byte-wide data RAM port, one byte per cycle. Misaligned stores and the
// reserved size code are rejected with an error pulse and no memory write.
//
// Configuration macro:
//   BIG_ENDIAN_EN  defined   -> byte at addr+k is byte (N-1-k) of the low N bytes
//                  undefined -> byte at addr+k is byte k (little-endian)
//
// Parameters:
//   ADDR_W       width of the byte address (default 10)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   i_valid      store request strobe
//   o_ready      unit idle; request accepted when i_valid && o_ready
//   i_addr       byte address of the store
//   i_size       access size: 00 byte, 01 halfword, 11 word, 10 reserved
//   i_data       register value to store
//   o_mem_we     byte write enable to the data RAM
//   o_mem_addr   byte address of the current write (held when o_mem_we=0)
//   o_mem_wdata  byte being written (held when o_mem_we=0)
//   o_done       one-cycle pulse: store completed
//   o_err        one-cycle pulse: store rejected
// -----------------------------------------------------------------------------
module mem_store_narrower #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_size,
    input  logic [31:0]       i_data,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_done,
    output logic              o_err
);

`ifdef BIG_ENDIAN_EN
    localparam bit BIG_ENDIAN = 1'b1;
`else
    localparam bit BIG_ENDIAN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // Index of the last byte written (N-1) for a given size code.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            2'b00:   last_index = 2'd0;
            2'b01:   last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    endfunction

    // Reserved size, or natural alignment violated for halfword/word.
    function automatic logic store_error(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
        case (size)
            2'b00:   store_error = 1'b0;
            2'b01:   store_error = addr_lo[0];
            2'b11:   store_error = (addr_lo != 2'b00);
            default: store_error = 1'b1;
        endcase
    endfunction

    // Byte that lands at addr+k. Only the low N bytes are ever addressed,
    // so upper bits of a narrow store never reach the RAM.
    function automatic logic [7:0] pick_byte(input logic [31:0] data,
                                             input logic [1:0]  last,
                                             input logic [1:0]  k);
        logic [1:0] idx;
        idx = BIG_ENDIAN ? (last - k) : k;
        case (idx)
            2'd0:    pick_byte = data[7:0];
            2'd1:    pick_byte = data[15:8];
            2'd2:    pick_byte = data[23:16];
            default: pick_byte = data[31:24];
        endcase
    endfunction

    // Control state
    state_t state_q, state_d;
    logic [1:0] k_q, k_d;

    // Request latched at accept; stable for the whole store
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [1:0]        last_q;
    logic              load;

    // Next values of the registered outputs
    logic              ready_d;
    logic              we_d;
    logic [ADDR_W-1:0] maddr_d;
    logic [7:0]        wdata_d;
    logic              done_d;
    logic              err_d;

    logic              accept;

    // o_ready is high in exactly the IDLE, DONE and ERR states, so it doubles
    // as the "can accept" qualifier for the handshake.
    assign accept = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        load    = 1'b0;
        ready_d = 1'b0;
        we_d    = 1'b0;
        maddr_d = o_mem_addr;
        wdata_d = o_mem_wdata;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_WRITE: begin
                if (k_q == last_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    k_d     = k_q + 2'd1;
                    we_d    = 1'b1;
                    maddr_d = addr_q + ADDR_W'(k_d);
                    wdata_d = pick_byte(data_q, last_q, k_d);
                end
            end
            default: begin
                // IDLE, DONE and ERR all behave as idle for a new request,
                // which gives back-to-back throughput of N+1 cycles.
                if (accept) begin
                    load = 1'b1;
                    if (store_error(i_size, i_addr[1:0])) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        // First byte goes out straight from the inputs so
                        // the write lands in the cycle right after accept.
                        state_d = S_WRITE;
                        k_d     = 2'd0;
                        we_d    = 1'b1;
                        maddr_d = i_addr;
                        wdata_d = pick_byte(i_data, last_index(i_size), 2'd0);
                    end
                end else begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            addr_q <= i_addr;
            data_q <= i_data;
            last_q <= last_index(i_size);
        end
    end

    // Registered outputs; reset aborts any store in flight without a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_ready     <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= 8'h00;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_ready     <= ready_d;
            o_mem_we    <= we_d;
            o_mem_addr  <= maddr_d;
            o_mem_wdata <= wdata_d;
            o_done      <= done_d;
            o_err       <= err_d;
        end
    end

endmodule
